// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
// Shared defaults and types for the elevator request queue slice.
//   DEF_LVL_W : default bits per floor level code
//   DEF_DEPTH : default number of queue slots
//   lvl_t     : one floor level code at the default width
//   cnt_t     : occupancy count at the default depth
// ----------------------------------------------------------------------------
package elevator_pkg;

   localparam int DEF_LVL_W = 2;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

   typedef logic [DEF_LVL_W-1:0] lvl_t;
   typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/elevator_req_queue_if.sv
// ----------------------------------------------------------------------------
// elevator_req_queue_if
// Bundles the request/arrival inputs and the queue status outputs.
//   add_valid/add_lvl       : new floor request from the button decoder
//   add_ready               : the request would be taken this cycle
//   arrive_valid/pos_lvl    : cab stopped at pos_lvl
//   head_lvl/head_valid     : oldest pending floor for the motion controller
//   count/full/dup_drop     : occupancy status and dropped-request pulse
// master = decoder/controller side, slave = the queue itself.
// ----------------------------------------------------------------------------
interface elevator_req_queue_if
   import elevator_pkg::*;
#(
   parameter int LVL_W = DEF_LVL_W,
   parameter int CNT_W = DEF_CNT_W
);

   logic             add_valid;
   logic [LVL_W-1:0] add_lvl;
   logic             add_ready;
   logic             arrive_valid;
   logic [LVL_W-1:0] pos_lvl;
   logic [LVL_W-1:0] head_lvl;
   logic             head_valid;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             dup_drop;

   modport master (
      output add_valid, add_lvl, arrive_valid, pos_lvl,
      input  add_ready, head_lvl, head_valid, count, full, dup_drop
   );

   modport slave (
      input  add_valid, add_lvl, arrive_valid, pos_lvl,
      output add_ready, head_lvl, head_valid, count, full, dup_drop
   );

endinterface

// File: rtl/elevator_slot_shift.sv
// ----------------------------------------------------------------------------
// elevator_slot_shift
// One removal cell of the compaction chain. Once any slot at or below this one
// matches the cab position, this slot takes its upper neighbour's value.
//   tmp_i, tmp_ip1 : this slot and the slot above it (after any append)
//   pos_lvl        : current cab level
//   valid_i        : this slot holds a live entry and an arrival is signalled
//   shift_im1      : a removal happened in a lower slot
//   next_slot_i    : value this slot loads next
//   shift_i        : removal happened at or below this slot
// ----------------------------------------------------------------------------
module elevator_slot_shift
   import elevator_pkg::*;
#(
   parameter int LVL_W = DEF_LVL_W
)(
   input  logic [LVL_W-1:0] tmp_i,
   input  logic [LVL_W-1:0] tmp_ip1,
   input  logic [LVL_W-1:0] pos_lvl,
   input  logic             valid_i,
   input  logic             shift_im1,
   output logic [LVL_W-1:0] next_slot_i,
   output logic             shift_i
);

   // The match is only meaningful for a live entry; dead slots are zero and
   // must never be mistaken for a request at floor 0.
   always_comb begin
      shift_i     = shift_im1 | (valid_i & (tmp_i == pos_lvl));
      next_slot_i = shift_i ? tmp_ip1 : tmp_i;
   end

endmodule

// File: rtl/elevator_req_queue.sv
// ----------------------------------------------------------------------------
// elevator_req_queue
// Ordered list of up to DEPTH distinct pending floors, oldest in slot 0.
// Each cycle one request may be appended and the floor the cab is stopped at
// is removed, with the entries above it shifting down one place.
//   clk, rst : clock and synchronous active-high reset
//   bus      : elevator_req_queue_if.slave (requests, arrivals, status)
// ----------------------------------------------------------------------------
module elevator_req_queue
   import elevator_pkg::*;
#(
   parameter int LVL_W = DEF_LVL_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic                 clk,
   input  logic                 rst,
   elevator_req_queue_if.slave  bus
);

   logic [LVL_W-1:0] r_slot [DEPTH];
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_headValid;
   logic             r_dupDrop;

   logic             w_hitOld;
   logic             w_dup;
   logic             w_acc;
   logic [LVL_W-1:0] w_tmp [DEPTH+1];
   logic [DEPTH-1:0] w_cellValid;
   logic             w_shiftChain [DEPTH+1];
   logic [LVL_W-1:0] w_nextSlot [DEPTH];
   logic [CNT_W-1:0] w_nextCount;

   // Decide whether the incoming request is taken. Acceptance when full depends
   // on an arrival freeing a slot; that is judged from the pre-append slots
   // only, since a freshly appended level can never be the one removed when
   // the queue was full (it would have to be absent and present at once).
   // The temporary list then carries the appended level at index count, and
   // each cell is told whether its entry is live for the arrival compare.
   always_comb begin
      w_hitOld    = 1'b0;
      w_dup       = 1'b0;
      w_cellValid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(r_count)) begin
            if (bus.arrive_valid && (r_slot[i] == bus.pos_lvl)) begin
               w_hitOld = 1'b1;
            end
            if (bus.add_valid && (r_slot[i] == bus.add_lvl)) begin
               w_dup = 1'b1;
            end
         end
      end
      w_acc = bus.add_valid & ~w_dup & (~r_full | w_hitOld);
      for (int i = 0; i < DEPTH; i++) begin
         w_tmp[i] = r_slot[i];
      end
      w_tmp[DEPTH] = '0;
      for (int i = 0; i <= DEPTH; i++) begin
         if (w_acc && (i == int'(r_count))) begin
            w_tmp[i] = bus.add_lvl;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         w_cellValid[i] = bus.arrive_valid & (i < (int'(r_count) + (w_acc ? 1 : 0)));
      end
   end

   // Compaction chain: the bottom of the chain starts with no removal pending
   // and its top end tells whether any entry was removed this cycle.
   assign w_shiftChain[0] = 1'b0;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : gSlot
         elevator_slot_shift #(.LVL_W(LVL_W)) uCell (
            .tmp_i       (w_tmp[g]),
            .tmp_ip1     (w_tmp[g+1]),
            .pos_lvl     (bus.pos_lvl),
            .valid_i     (w_cellValid[g]),
            .shift_im1   (w_shiftChain[g]),
            .next_slot_i (w_nextSlot[g]),
            .shift_i     (w_shiftChain[g+1])
         );
      end
   endgenerate

   // Modular arithmetic is fine here: the true result never exceeds DEPTH even
   // though count+1 may briefly not fit when a full queue swaps an entry.
   assign w_nextCount = r_count + CNT_W'(w_acc) - CNT_W'(w_shiftChain[DEPTH]);

   // Register the list and derive the status flags from the next count so all
   // outputs change together on the same edge. Reset wins over any traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot      <= '{default: '0};
         r_count     <= '0;
         r_full      <= 1'b0;
         r_headValid <= 1'b0;
         r_dupDrop   <= 1'b0;
      end else begin
         r_slot      <= w_nextSlot;
         r_count     <= w_nextCount;
         r_full      <= (w_nextCount == CNT_W'(DEPTH));
         r_headValid <= (w_nextCount != '0);
         r_dupDrop   <= bus.add_valid & ~w_acc;
      end
   end

   assign bus.add_ready  = ~r_full | w_hitOld;
   assign bus.head_lvl   = r_slot[0];
   assign bus.head_valid = r_headValid;
   assign bus.count      = r_count;
   assign bus.full       = r_full;
   assign bus.dup_drop   = r_dupDrop;

endmodule

// File: tb/tb_elevator_req_queue.sv
// ----------------------------------------------------------------------------
// tb_elevator_req_queue
// Exercises a DEPTH=4 and a DEPTH=3 queue with directed scenarios and random
// traffic compared against a floor-list model.
// ----------------------------------------------------------------------------
module tb_elevator_req_queue;
   import elevator_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic obsReady;
   int   oCount;
   lvl_t oHead;
   logic oHv;
   logic oFull;
   logic oDup;

   elevator_req_queue_if #(.LVL_W(2), .CNT_W(3)) b4 ();
   elevator_req_queue_if #(.LVL_W(2), .CNT_W(2)) b3 ();

   elevator_req_queue #(.LVL_W(2), .DEPTH(4), .CNT_W(3)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   elevator_req_queue #(.LVL_W(2), .DEPTH(3), .CNT_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Capture the registered outputs of the chosen queue
   task automatic sampleOutputs(input int which);
      if (which == 4) begin
         oCount = int'(b4.count); oHead = b4.head_lvl; oHv = b4.head_valid;
         oFull = b4.full; oDup = b4.dup_drop;
      end else begin
         oCount = int'(b3.count); oHead = b3.head_lvl; oHv = b3.head_valid;
         oFull = b3.full; oDup = b3.dup_drop;
      end
   endtask

   // Drive one cycle of traffic into one queue, read add_ready before the edge
   // and the registered outputs just after it
   task automatic applyStimulus(input int which, input logic av, input lvl_t al,
                                input logic rv, input lvl_t pl);
      if (which == 4) begin
         b4.add_valid = av; b4.add_lvl = al; b4.arrive_valid = rv; b4.pos_lvl = pl;
      end else begin
         b3.add_valid = av; b3.add_lvl = al; b3.arrive_valid = rv; b3.pos_lvl = pl;
      end
      #1;
      obsReady = (which == 4) ? b4.add_ready : b3.add_ready;
      @(posedge clk);
      #1;
      b4.add_valid = 1'b0; b4.arrive_valid = 1'b0; b4.add_lvl = '0; b4.pos_lvl = '0;
      b3.add_valid = 1'b0; b3.arrive_valid = 1'b0; b3.add_lvl = '0; b3.pos_lvl = '0;
      sampleOutputs(which);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sampleOutputs(4);
   endtask

   task automatic test_reset();
      doReset();
      total++; if (oCount !== 0)    begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", oCount); end
      total++; if (oHv !== 1'b0)    begin bad++; $display("[TB] FAIL reset_head_valid got=%0b want=0", oHv); end
      total++; if (oHead !== 2'd0)  begin bad++; $display("[TB] FAIL reset_head_lvl got=%0d want=0", oHead); end
      total++; if (oFull !== 1'b0)  begin bad++; $display("[TB] FAIL reset_full got=%0b want=0", oFull); end
      total++; if (oDup !== 1'b0)   begin bad++; $display("[TB] FAIL reset_dup_drop got=%0b want=0", oDup); end
      total++; if (b3.count !== 2'd0) begin bad++; $display("[TB] FAIL reset_count3 got=%0d want=0", b3.count); end
   endtask

   task automatic test_add();
      lvl_t e[4];
      applyStimulus(4, 1'b1, 2'd2, 1'b0, 2'd0);
      total++; if (oHead !== 2'd2 || oHv !== 1'b1) begin bad++; $display("[TB] FAIL add_first_head got=%0d/%0b want=2/1", oHead, oHv); end
      applyStimulus(4, 1'b1, 2'd1, 1'b0, 2'd0);
      applyStimulus(4, 1'b1, 2'd3, 1'b0, 2'd0);
      e = '{2'd2, 2'd1, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
         total++; if (dut4.r_slot[i] !== e[i]) begin bad++; $display("[TB] FAIL add_slot%0d got=%0d want=%0d", i, dut4.r_slot[i], e[i]); end
      end
      total++; if (oCount !== 3)   begin bad++; $display("[TB] FAIL add_count got=%0d want=3", oCount); end
      total++; if (oHead !== 2'd2) begin bad++; $display("[TB] FAIL add_head got=%0d want=2", oHead); end
      total++; if (oFull !== 1'b0) begin bad++; $display("[TB] FAIL add_full got=%0b want=0", oFull); end
   endtask

   task automatic test_arrive();
      lvl_t e[4];
      applyStimulus(4, 1'b0, 2'd0, 1'b1, 2'd1);
      e = '{2'd2, 2'd3, 2'd0, 2'd0};
      for (int i = 0; i < 4; i++) begin
         total++; if (dut4.r_slot[i] !== e[i]) begin bad++; $display("[TB] FAIL arrive_slot%0d got=%0d want=%0d", i, dut4.r_slot[i], e[i]); end
      end
      total++; if (oCount !== 2) begin bad++; $display("[TB] FAIL arrive_count got=%0d want=2", oCount); end
      applyStimulus(4, 1'b0, 2'd0, 1'b1, 2'd0);
      total++; if (oCount !== 2 || oHead !== 2'd2) begin bad++; $display("[TB] FAIL arrive_absent got=%0d/%0d want=2/2", oCount, oHead); end
      total++; if (dut4.r_slot[1] !== 2'd3) begin bad++; $display("[TB] FAIL arrive_absent_slot1 got=%0d want=3", dut4.r_slot[1]); end
   endtask

   task automatic test_dup();
      lvl_t e[4];
      applyStimulus(4, 1'b1, 2'd3, 1'b0, 2'd0);
      total++; if (oDup !== 1'b1) begin bad++; $display("[TB] FAIL dup_pulse got=%0b want=1", oDup); end
      total++; if (oCount !== 2)  begin bad++; $display("[TB] FAIL dup_count got=%0d want=2", oCount); end
      applyStimulus(4, 1'b1, 2'd0, 1'b1, 2'd0);
      total++; if (oDup !== 1'b0) begin bad++; $display("[TB] FAIL same_lvl_dup got=%0b want=0", oDup); end
      total++; if (oCount !== 2)  begin bad++; $display("[TB] FAIL same_lvl_count got=%0d want=2", oCount); end
      e = '{2'd2, 2'd3, 2'd0, 2'd0};
      for (int i = 0; i < 4; i++) begin
         total++; if (dut4.r_slot[i] !== e[i]) begin bad++; $display("[TB] FAIL same_lvl_slot%0d got=%0d want=%0d", i, dut4.r_slot[i], e[i]); end
      end
   endtask

   task automatic test_full();
      lvl_t e[4];
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(4, 1'b1, 2'(i), 1'b0, 2'd0);
      total++; if (oFull !== 1'b1 || oCount !== 4) begin bad++; $display("[TB] FAIL full_set got=%0b/%0d want=1/4", oFull, oCount); end
      applyStimulus(4, 1'b1, 2'd3, 1'b0, 2'd0);
      total++; if (obsReady !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%0b want=0", obsReady); end
      total++; if (oDup !== 1'b1)     begin bad++; $display("[TB] FAIL full_dup got=%0b want=1", oDup); end
      e = '{2'd0, 2'd1, 2'd2, 2'd3};
      for (int i = 0; i < 4; i++) begin
         total++; if (dut4.r_slot[i] !== e[i]) begin bad++; $display("[TB] FAIL full_slot%0d got=%0d want=%0d", i, dut4.r_slot[i], e[i]); end
      end
      for (int i = 0; i < 3; i++) applyStimulus(3, 1'b1, 2'(i), 1'b0, 2'd0);
      total++; if (oFull !== 1'b1) begin bad++; $display("[TB] FAIL full3_set got=%0b want=1", oFull); end
      applyStimulus(3, 1'b1, 2'd3, 1'b1, 2'd0);
      total++; if (obsReady !== 1'b1) begin bad++; $display("[TB] FAIL swap_ready got=%0b want=1", obsReady); end
      total++; if (oCount !== 3 || oFull !== 1'b1 || oDup !== 1'b0) begin bad++; $display("[TB] FAIL swap_status got=%0d/%0b/%0b want=3/1/0", oCount, oFull, oDup); end
      e = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 3; i++) begin
         total++; if (dut3.r_slot[i] !== e[i]) begin bad++; $display("[TB] FAIL swap_slot%0d got=%0d want=%0d", i, dut3.r_slot[i], e[i]); end
      end
   endtask

   task automatic test_head();
      applyStimulus(3, 1'b0, 2'd0, 1'b1, 2'd1);
      total++; if (oHead !== 2'd2 || oCount !== 2) begin bad++; $display("[TB] FAIL head_pop1 got=%0d/%0d want=2/2", oHead, oCount); end
      applyStimulus(3, 1'b0, 2'd0, 1'b1, 2'd2);
      total++; if (oHead !== 2'd3 || oCount !== 1) begin bad++; $display("[TB] FAIL head_pop2 got=%0d/%0d want=3/1", oHead, oCount); end
      applyStimulus(3, 1'b0, 2'd0, 1'b1, 2'd3);
      total++; if (oHv !== 1'b0 || oCount !== 0 || oHead !== 2'd0) begin bad++; $display("[TB] FAIL head_empty got=%0b/%0d/%0d want=0/0/0", oHv, oCount, oHead); end
      applyStimulus(3, 1'b0, 2'd0, 1'b1, 2'd0);
      total++; if (oCount !== 0 || oHv !== 1'b0) begin bad++; $display("[TB] FAIL empty_arrive got=%0d/%0b want=0/0", oCount, oHv); end
   endtask

   task automatic test_reset_mid();
      doReset();
      applyStimulus(4, 1'b1, 2'd1, 1'b0, 2'd0);
      applyStimulus(4, 1'b1, 2'd2, 1'b0, 2'd0);
      b4.add_valid = 1'b1; b4.add_lvl = 2'd3; b4.arrive_valid = 1'b1; b4.pos_lvl = 2'd1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      b4.add_valid = 1'b0; b4.arrive_valid = 1'b0; b4.add_lvl = '0; b4.pos_lvl = '0;
      sampleOutputs(4);
      total++; if (oCount !== 0 || oHv !== 1'b0 || oHead !== 2'd0 || oFull !== 1'b0 || oDup !== 1'b0) begin
         bad++; $display("[TB] FAIL rst_mid got=%0d/%0b/%0d/%0b/%0b want=0/0/0/0/0", oCount, oHv, oHead, oFull, oDup);
      end
      for (int i = 0; i < 4; i++) begin
         total++; if (dut4.r_slot[i] !== 2'd0) begin bad++; $display("[TB] FAIL rst_mid_slot%0d got=%0d want=0", i, dut4.r_slot[i]); end
      end
      @(posedge clk);
      #1;
      sampleOutputs(4);
      total++; if (oCount !== 0 || oHv !== 1'b0) begin bad++; $display("[TB] FAIL rst_release got=%0d/%0b want=0/0", oCount, oHv); end
   endtask

   // Random traffic against a plain list of pending floors: append if new and
   // room (or the arrival frees room), then drop the arrival floor if listed
   task automatic test_random(input int which, input int depth, input int cycles);
      lvl_t q[$];
      logic av, rv, eReady, acc, eDup;
      lvl_t al, pl, eHead;
      int   posIdx, addIdx;
      doReset();
      for (int n = 0; n < cycles; n++) begin
         av = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 2) == 0);
         al = 2'($urandom_range(0, 3));
         pl = 2'($urandom_range(0, 3));
         posIdx = -1;
         addIdx = -1;
         foreach (q[k]) begin
            if (q[k] == pl) posIdx = k;
            if (q[k] == al) addIdx = k;
         end
         eReady = (q.size() < depth) || (rv && posIdx >= 0);
         acc    = av && (addIdx < 0) && eReady;
         eDup   = av && !acc;
         if (acc) q.push_back(al);
         if (rv) begin
            posIdx = -1;
            foreach (q[k]) if (q[k] == pl) posIdx = k;
            if (posIdx >= 0) q.delete(posIdx);
         end
         eHead = (q.size() != 0) ? q[0] : 2'd0;
         applyStimulus(which, av, al, rv, pl);
         total++; if (obsReady !== eReady) begin bad++; $display("[TB] FAIL rnd%0d_ready n=%0d got=%0b want=%0b", depth, n, obsReady, eReady); end
         total++; if (oCount !== q.size()) begin bad++; $display("[TB] FAIL rnd%0d_count n=%0d got=%0d want=%0d", depth, n, oCount, q.size()); end
         total++; if (oHead !== eHead) begin bad++; $display("[TB] FAIL rnd%0d_head n=%0d got=%0d want=%0d", depth, n, oHead, eHead); end
         total++; if (oHv !== (q.size() != 0) || oFull !== (q.size() == depth)) begin
            bad++; $display("[TB] FAIL rnd%0d_flags n=%0d got=%0b/%0b want=%0b/%0b", depth, n, oHv, oFull, q.size() != 0, q.size() == depth);
         end
         total++; if (oDup !== eDup) begin bad++; $display("[TB] FAIL rnd%0d_dup n=%0d got=%0b want=%0b", depth, n, oDup, eDup); end
      end
   endtask

   // Guard against a stalled run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      total = 0;
      bad = 0;
      b4.add_valid = 1'b0; b4.arrive_valid = 1'b0; b4.add_lvl = '0; b4.pos_lvl = '0;
      b3.add_valid = 1'b0; b3.arrive_valid = 1'b0; b3.add_lvl = '0; b3.pos_lvl = '0;
      test_reset();
      test_add();
      test_arrive();
      test_dup();
      test_full();
      test_head();
      test_reset_mid();
      test_random(4, 4, 400);
      test_random(3, 3, 400);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
